// File: rtl/uart_mmio_pkg.sv
// Shared constants for the UART TX MMIO controller: default register map,
// STATUS bit positions and the TX sequencing FSM encoding.
package uart_mmio_pkg;

  localparam logic [7:0] ADDR_DATA_DEF   = 8'h10;
  localparam logic [7:0] ADDR_STATUS_DEF = 8'h14;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_BUSY    = 3;
  localparam int ST_IRQ     = 4;
  localparam int ST_CNT_LSB = 8;

  // Write-1-to-clear bit positions in a STATUS store.
  localparam int CLR_OVF_BIT = 2;
  localparam int CLR_IRQ_BIT = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_ctrl_if.sv
// CPU MMIO bus plus UART tx handshake; master is the CPU/UART side, slave the controller.
// tx_irq exists only when UART_TX_IRQ_EN is defined.
interface uart_tx_mmio_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_we;
  logic [31:0]       bus_rdata;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
`ifdef UART_TX_IRQ_EN
  logic              tx_irq;
`endif

  modport master (
    output bus_addr, bus_wdata, bus_we, tx_busy,
    input  bus_rdata, tx_data, tx_start
`ifdef UART_TX_IRQ_EN
    , input tx_irq
`endif
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, tx_busy,
    output bus_rdata, tx_data, tx_start
`ifdef UART_TX_IRQ_EN
    , output tx_irq
`endif
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy count; pointers wrap modulo DEPTH (power of 2).
// Caller guarantees no push when full and no pop when empty.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     din_i,
  input  logic             pop_i,
  output logic [W-1:0]     dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_mmio_ctrl.sv
// MMIO front-end feeding the UART transmitter from a TX byte FIFO, with STATUS polling.
// Optional completion interrupt is built only when UART_TX_IRQ_EN is defined.
module uart_tx_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int              ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] ADDR_DATA   = ADDR_W'(ADDR_DATA_DEF),
  parameter logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(ADDR_STATUS_DEF),
  parameter int              FIFO_DEPTH  = 8
) (
  input logic                clk,
  input logic                rst_n,
  uart_tx_mmio_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             data_wr, status_wr, push, drop;
  logic             ovf_q, ovf_d;
  tx_state_e        state_q;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic [31:0]      status;
  logic             unused_wdata;

  assign data_wr   = bus.bus_we && (bus.bus_addr == ADDR_DATA);
  assign status_wr = bus.bus_we && (bus.bus_addr == ADDR_STATUS);
  // Full is taken before any same-cycle pop, so a store to a full FIFO drops.
  assign push      = data_wr && !fifo_full;
  assign drop      = data_wr && fifo_full;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty && !bus.tx_busy;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (bus.bus_wdata[7:0]),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (status_wr && bus.bus_wdata[CLR_OVF_BIT]) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            tx_data_q  <= fifo_head;
            tx_start_q <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          tx_start_q <= 1'b0;
          state_q    <= bus.tx_busy ? WAIT_DONE : WAIT_BUSY;
        end
        WAIT_BUSY: if (bus.tx_busy)  state_q <= WAIT_DONE;
        WAIT_DONE: if (!bus.tx_busy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

`ifdef UART_TX_IRQ_EN
  logic irq_q, irq_d;

  // Raised on the WAIT_DONE->IDLE step that leaves nothing queued; clear wins.
  always_comb begin
    irq_d = irq_q;
    if ((state_q == WAIT_DONE) && !bus.tx_busy && fifo_empty) irq_d = 1'b1;
    if (push || (status_wr && bus.bus_wdata[CLR_IRQ_BIT])) irq_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign bus.tx_irq = irq_q;
`endif

  always_comb begin
    status                    = '0;
    status[ST_FULL]           = fifo_full;
    status[ST_EMPTY]          = fifo_empty;
    status[ST_OVF]            = ovf_q;
    status[ST_BUSY]           = (state_q != IDLE);
    status[ST_CNT_LSB +: 8]   = 8'(fifo_count);
`ifdef UART_TX_IRQ_EN
    status[ST_IRQ]            = irq_q;
`endif
  end

  always_comb begin
    bus.bus_rdata = '0;
    if (bus.bus_addr == ADDR_STATUS) bus.bus_rdata = status;
  end

  assign unused_wdata = ^bus.bus_wdata;

endmodule

// File: tb/tb_uart_tx_mmio_ctrl.sv
// Directed bench for uart_tx_mmio_ctrl: register-map vector table plus TX sequencing scenarios
// against a behavioural UART tx that answers tx_start with a busy window.
module tb_uart_tx_mmio_ctrl;

  localparam logic [7:0] A_DATA = 8'h10;
  localparam logic [7:0] A_STAT = 8'h14;
  localparam logic [7:0] A_NONE = 8'h20;
`ifdef UART_TX_IRQ_EN
  localparam logic [31:0] IDLE_ST = 32'h0000_0012;
`else
  localparam logic [31:0] IDLE_ST = 32'h0000_0002;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_mmio_ctrl_if #(.ADDR_W(8)) bus ();

  uart_tx_mmio_ctrl #(
    .ADDR_W(8), .ADDR_DATA(8'h10), .ADDR_STATUS(8'h14), .FIFO_DEPTH(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks = 0;
  int         passed = 0;
  int         starts = 0;
  logic [7:0] sent[$];
  bit         force_busy = 1'b0;
  bit         late = 1'b0;
  int         busy_len = 5;
  int         dly = 0;
  int         cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Behavioural UART tx: busy immediately (or one cycle late) after tx_start, for busy_len cycles.
  always @(negedge clk) begin
    if (force_busy) begin
      bus.tx_busy = 1'b1;
    end else if (bus.tx_start) begin
      check("start_while_busy", {31'd0, bus.tx_busy}, 32'd0);
      sent.push_back(bus.tx_data);
      starts++;
      if (late) dly = 1;
      else begin
        bus.tx_busy = 1'b1;
        cnt = busy_len;
      end
    end else if (dly > 0) begin
      dly = 0;
      bus.tx_busy = 1'b1;
      cnt = busy_len;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) bus.tx_busy = 1'b0;
    end else begin
      bus.tx_busy = 1'b0;
    end
  end

  task automatic rd(input logic [7:0] addr, output logic [31:0] data);
    bus.bus_we   = 1'b0;
    bus.bus_addr = addr;
    #1;
    data = bus.bus_rdata;
  endtask

  task automatic store(input logic [7:0] addr, input logic [31:0] data);
    bus.bus_addr  = addr;
    bus.bus_wdata = data;
    bus.bus_we    = 1'b1;
    @(negedge clk);
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 8'h00;
  endtask

  task automatic wait_drain(input int budget, input string name);
    logic [31:0] s;
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      rd(A_STAT, s);
      if (!s[3] && s[1] && !bus.tx_busy) done = 1'b1;
    end
    check({name, "_drained"}, {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    int base;

    tv[0]  = '{1'b0, A_DATA, 32'h0,         A_STAT, 32'h0000_0002};
    tv[1]  = '{1'b0, A_DATA, 32'h0,         A_DATA, 32'h0000_0000};
    tv[2]  = '{1'b1, A_DATA, 32'hFFFF_FF30, A_STAT, 32'h0000_0100};
    tv[3]  = '{1'b1, A_NONE, 32'h0000_0055, A_NONE, 32'h0000_0000};
    tv[4]  = '{1'b1, A_DATA, 32'h0000_0031, A_STAT, 32'h0000_0200};
    tv[5]  = '{1'b1, A_DATA, 32'h0000_0032, A_STAT, 32'h0000_0300};
    tv[6]  = '{1'b1, A_DATA, 32'h0000_0033, A_STAT, 32'h0000_0400};
    tv[7]  = '{1'b1, A_DATA, 32'h0000_0034, A_STAT, 32'h0000_0500};
    tv[8]  = '{1'b1, A_DATA, 32'h0000_0035, A_STAT, 32'h0000_0600};
    tv[9]  = '{1'b1, A_DATA, 32'h0000_0036, A_STAT, 32'h0000_0700};
    tv[10] = '{1'b1, A_DATA, 32'h0000_0037, A_STAT, 32'h0000_0801};
    tv[11] = '{1'b1, A_DATA, 32'h0000_0038, A_STAT, 32'h0000_0805};
    tv[12] = '{1'b1, A_STAT, 32'h0000_0008, A_STAT, 32'h0000_0805};
    tv[13] = '{1'b1, A_STAT, 32'h0000_0004, A_STAT, 32'h0000_0801};
    tv[14] = '{1'b1, A_DATA, 32'h0000_0039, A_STAT, 32'h0000_0805};
    tv[15] = '{1'b1, A_STAT, 32'hFFFF_FFFF, A_STAT, 32'h0000_0801};

    bus.bus_addr  = 8'h00;
    bus.bus_wdata = 32'h0;
    bus.bus_we    = 1'b0;
    bus.tx_busy   = 1'b1;
    force_busy    = 1'b1;

    // Power-on reset state
    #1;
    rd(A_STAT, s);
    check("reset_status", s, 32'h0000_0002);
    check("reset_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("reset_tx_data", {24'd0, bus.tx_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Register map, burst fill and overflow while the UART holds busy
    for (int i = 0; i < 16; i++) begin
      bus.bus_we    = tv[i].we;
      bus.bus_addr  = tv[i].addr;
      bus.bus_wdata = tv[i].wdata;
      @(negedge clk);
      rd(tv[i].rd_addr, s);
      check($sformatf("vec%0d", i), s, tv[i].exp);
    end
    check("no_start_while_forced", starts, 0);

    // Drain the burst: bytes must come out in push order
    force_busy = 1'b0;
    busy_len   = 5;
    @(negedge clk);
    wait_drain(400, "burst");
    check("burst_starts", starts, 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("burst_byte%0d", i), {24'd0, sent[i]}, 32'h30 + i);
    rd(A_STAT, s);
    check("burst_idle_status", s, IDLE_ST);
`ifdef UART_TX_IRQ_EN
    check("irq_after_burst", {31'd0, bus.tx_irq}, 32'd1);
`endif

    // Single byte with 20-cycle busy: latency, pulse width, data stability
    busy_len = 20;
    sent.delete();
    base = starts;
    store(A_DATA, 32'h0000_0041);
    check("lat_edge_n", {31'd0, bus.tx_start}, 32'd0);
    @(negedge clk);
    check("lat_edge_n1", {31'd0, bus.tx_start}, 32'd1);
    check("single_data", {24'd0, bus.tx_data}, 32'h41);
    rd(A_STAT, s);
    check("single_status", s, 32'h0000_000A);
    @(negedge clk);
    check("start_one_cycle", {31'd0, bus.tx_start}, 32'd0);
    repeat (10) @(negedge clk);
    check("data_stable_busy", {24'd0, bus.tx_data}, 32'h41);
    wait_drain(100, "single");
    check("single_starts", starts - base, 1);
    check("single_sent", {24'd0, sent[0]}, 32'h41);

    // UART raises busy one cycle late: no duplicate start, order kept
    late     = 1'b1;
    busy_len = 6;
    sent.delete();
    base = starts;
    store(A_DATA, 32'h0000_005A);
    store(A_DATA, 32'h0000_00A5);
`ifdef UART_TX_IRQ_EN
    check("irq_cleared_by_push", {31'd0, bus.tx_irq}, 32'd0);
`endif
    wait_drain(200, "late");
    check("late_starts", starts - base, 2);
    check("late_byte0", {24'd0, sent[0]}, 32'h5A);
    check("late_byte1", {24'd0, sent[1]}, 32'hA5);
    late = 1'b0;
`ifdef UART_TX_IRQ_EN
    check("irq_after_two", {31'd0, bus.tx_irq}, 32'd1);
    store(A_STAT, 32'h0000_0008);
    check("irq_w1c", {31'd0, bus.tx_irq}, 32'd0);
`else
    rd(A_STAT, s);
    check("status_irq_bit_zero", {31'd0, s[4]}, 32'd0);
`endif

    // Reset in the middle of a frame with a byte still queued
    busy_len = 20;
    store(A_DATA, 32'h0000_0061);
    store(A_DATA, 32'h0000_0062);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("midrst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    rd(A_STAT, s);
    check("midrst_status", s, 32'h0000_0002);
    @(negedge clk);
    rst_n = 1'b1;
    base = starts;
    repeat (40) @(negedge clk);
    check("midrst_no_resend", starts - base, 0);
    rd(A_STAT, s);
    check("midrst_after_status", s, 32'h0000_0002);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
